card_dealer: RTL and testbench

- Producer side of the game's card/total datapath.
- On request, draws a pseudo-random card, adds it to the player or dealer hand and applies soft-ace correction.
- Presents 5-bit card values, hand totals and a 2-bit display select. The downstream 3-to-1 value mux and game-result gate consume these (00 player, 01 dealer, 10 result).

---
 rtl/card_dealer.sv | 201 ++++++++++++++++++++
 tb/tb_card_dealer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Card producer: draws LFSR or forced ranks into the player/dealer hand,
// applies soft-ace correction and presents totals, bust flags and display select.
module card_dealer #(
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          BUST_LIMIT = 21
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       new_hand,
   input  logic       deal_req,
   input  logic       deal_target,
   input  logic       card_load,
   input  logic [3:0] card_rank,
   output logic       busy,
   output logic       card_valid,
   output logic [4:0] card_value,
   output logic       card_target,
   output logic [4:0] player_total,
   output logic [4:0] dealer_total,
   output logic       player_bust,
   output logic       dealer_bust,
   output logic [1:0] disp_sel
);
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DRAW = 3'd1,
      ADD  = 3'd2,
      ADJ  = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam logic [5:0] LIMIT = 6'(BUST_LIMIT);

   function automatic logic [4:0] rank_value(input logic [3:0] rank);
      logic [4:0] v;
      if (rank == 4'd1) v = 5'd11;
      else if (rank >= 4'd11) v = 5'd10;
      else v = {1'b0, rank};
      return v;
   endfunction

   function automatic logic [4:0] sat31(input logic [5:0] t);
      return (t > 6'd31) ? 5'd31 : t[4:0];
   endfunction

   state_t      state_r, state_nx;
   logic [15:0] lfsr_r, lfsr_nx;
   logic        tgt_r, tgt_nx, load_r, load_nx;
   logic [3:0]  rank_r, rank_nx;
   logic [5:0]  p_sum_r, p_sum_nx, d_sum_r, d_sum_nx;
   logic [1:0]  p_soft_r, p_soft_nx, d_soft_r, d_soft_nx;
   logic [5:0]  cur_sum_s, sum_upd_s;
   logic [1:0]  cur_soft_s, soft_upd_s;
   logic [3:0]  draw_rank_s;
   logic        rank_ok_s;
   logic [4:0]  value_nx;
   logic        target_nx, valid_nx, pbust_nx, dbust_nx;
   logic [1:0]  disp_nx;

   // Next-state, draw, accumulate and ace-downgrade logic
   always_comb begin
      state_nx   = state_r;
      lfsr_nx    = {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
      tgt_nx     = tgt_r;
      load_nx    = load_r;
      rank_nx    = rank_r;
      value_nx   = card_value;
      target_nx  = card_target;
      valid_nx   = 1'b0;
      pbust_nx   = player_bust;
      dbust_nx   = dealer_bust;
      disp_nx    = disp_sel;
      cur_sum_s  = tgt_r ? d_sum_r : p_sum_r;
      cur_soft_s = tgt_r ? d_soft_r : p_soft_r;
      sum_upd_s  = cur_sum_s;
      soft_upd_s = cur_soft_s;
      if (load_r) begin
         draw_rank_s = (rank_r >= 4'd1 && rank_r <= 4'd13) ? rank_r : 4'd10;
      end else begin
         draw_rank_s = lfsr_r[3:0];
      end
      rank_ok_s = (draw_rank_s != 4'd0) && (draw_rank_s <= 4'd13);

      case (state_r)
         IDLE: begin
            if (deal_req && !(deal_target ? dealer_bust : player_bust)) begin
               state_nx = DRAW;
               tgt_nx   = deal_target;
               load_nx  = card_load;
               rank_nx  = card_rank;
            end else begin
               state_nx = IDLE;
            end
         end
         DRAW: begin
            if (rank_ok_s) begin
               value_nx = rank_value(draw_rank_s);
               state_nx = ADD;
            end else begin
               state_nx = DRAW;
            end
         end
         ADD: begin
            sum_upd_s = cur_sum_s + {1'b0, card_value};
            if (card_value == 5'd11 && cur_soft_s != 2'd3) begin
               soft_upd_s = cur_soft_s + 2'd1;
            end else begin
               soft_upd_s = cur_soft_s;
            end
            state_nx = ADJ;
         end
         ADJ: begin
            // One soft ace downgraded per cycle until the hand fits or no soft aces remain
            if (cur_sum_s > LIMIT && cur_soft_s != 2'd0) begin
               sum_upd_s  = cur_sum_s - 6'd10;
               soft_upd_s = cur_soft_s - 2'd1;
               state_nx   = ADJ;
            end else begin
               state_nx  = DONE;
               valid_nx  = 1'b1;
               target_nx = tgt_r;
               pbust_nx  = (p_sum_r > LIMIT);
               dbust_nx  = (d_sum_r > LIMIT);
               disp_nx   = ((p_sum_r > LIMIT) || (d_sum_r > LIMIT)) ? 2'b10 : {1'b0, tgt_r};
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      p_sum_nx  = tgt_r ? p_sum_r  : sum_upd_s;
      p_soft_nx = tgt_r ? p_soft_r : soft_upd_s;
      d_sum_nx  = tgt_r ? sum_upd_s  : d_sum_r;
      d_soft_nx = tgt_r ? soft_upd_s : d_soft_r;

      if (new_hand) begin
         state_nx  = IDLE;
         p_sum_nx  = 6'd0;
         d_sum_nx  = 6'd0;
         p_soft_nx = 2'd0;
         d_soft_nx = 2'd0;
         valid_nx  = 1'b0;
         pbust_nx  = 1'b0;
         dbust_nx  = 1'b0;
         disp_nx   = 2'b00;
      end else begin
         state_nx = state_nx;
      end
   end

   // FSM state register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_r <= IDLE;
      else         state_r <= state_nx;
   end

   // Datapath and registered outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         lfsr_r       <= LFSR_SEED;
         tgt_r        <= 1'b0;
         load_r       <= 1'b0;
         rank_r       <= 4'd0;
         p_sum_r      <= 6'd0;
         d_sum_r      <= 6'd0;
         p_soft_r     <= 2'd0;
         d_soft_r     <= 2'd0;
         busy         <= 1'b0;
         card_valid   <= 1'b0;
         card_value   <= 5'd0;
         card_target  <= 1'b0;
         player_total <= 5'd0;
         dealer_total <= 5'd0;
         player_bust  <= 1'b0;
         dealer_bust  <= 1'b0;
         disp_sel     <= 2'b00;
      end else begin
         lfsr_r       <= lfsr_nx;
         tgt_r        <= tgt_nx;
         load_r       <= load_nx;
         rank_r       <= rank_nx;
         p_sum_r      <= p_sum_nx;
         d_sum_r      <= d_sum_nx;
         p_soft_r     <= p_soft_nx;
         d_soft_r     <= d_soft_nx;
         busy         <= (state_nx != IDLE);
         card_valid   <= valid_nx;
         card_value   <= value_nx;
         card_target  <= target_nx;
         player_total <= sat31(p_sum_nx);
         dealer_total <= sat31(d_sum_nx);
         player_bust  <= pbust_nx;
         dealer_bust  <= dbust_nx;
         disp_sel     <= disp_nx;
      end
   end
endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: directed hands plus randomized LFSR deals
// compared against a hand-level reference model.
module tb_card_dealer;
   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       new_hand = 1'b0;
   logic       deal_req = 1'b0;
   logic       deal_target = 1'b0;
   logic       card_load = 1'b0;
   logic [3:0] card_rank = 4'd0;
   logic       busy, card_valid, card_target, player_bust, dealer_bust;
   logic [4:0] card_value, player_total, dealer_total;
   logic [1:0] disp_sel;

   card_dealer dut (
      .clock(clock), .resetn(resetn), .new_hand(new_hand), .deal_req(deal_req),
      .deal_target(deal_target), .card_load(card_load), .card_rank(card_rank),
      .busy(busy), .card_valid(card_valid), .card_value(card_value),
      .card_target(card_target), .player_total(player_total), .dealer_total(dealer_total),
      .player_bust(player_bust), .dealer_bust(dealer_bust), .disp_sel(disp_sel)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int last_lat = 0;

   // Reference state: one entry per hand, 0 = player, 1 = dealer
   logic [15:0] m_lfsr;
   int m_total[2];
   int m_soft[2];
   int m_bust[2];
   int m_disp = 0;
   int m_val = 0;
   int m_tgt = 0;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   function automatic int card_val(input int r);
      if (r == 1) return 11;
      if (r >= 11) return 10;
      return r;
   endfunction

   // Free-running copy of the card stream
   always @(posedge clock or negedge resetn) begin
      if (!resetn) m_lfsr <= 16'hACE1;
      else         m_lfsr <= lfsr_step(m_lfsr);
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string ctx);
      check_eq({ctx, "_ptot"}, player_total, (m_total[0] > 31) ? 31 : m_total[0]);
      check_eq({ctx, "_dtot"}, dealer_total, (m_total[1] > 31) ? 31 : m_total[1]);
      check_eq({ctx, "_pbust"}, player_bust, m_bust[0]);
      check_eq({ctx, "_dbust"}, dealer_bust, m_bust[1]);
      check_eq({ctx, "_disp"}, disp_sel, m_disp);
      check_eq({ctx, "_value"}, card_value, m_val);
      check_eq({ctx, "_target"}, card_target, m_tgt);
   endtask

   task automatic model_clear();
      for (int h = 0; h < 2; h++) begin
         m_total[h] = 0;
         m_soft[h]  = 0;
         m_bust[h]  = 0;
      end
      m_disp = 0;
   endtask

   task automatic do_new_hand();
      new_hand = 1'b1;
      @(posedge clock); #1;
      new_hand = 1'b0;
      model_clear();
      check_eq("nh_busy", busy, 0);
      check_eq("nh_valid", card_valid, 0);
      check_outputs("nh");
   endtask

   task automatic deal(input int tgt, input int load, input int rank);
      logic [15:0] s;
      int rej, down, exp_rank, v, lat;
      bit seen;
      deal_req    = 1'b1;
      deal_target = tgt[0];
      card_load   = load[0];
      card_rank   = rank[3:0];
      @(posedge clock); #1;
      deal_req  = 1'b0;
      card_load = 1'b0;
      if (m_bust[tgt] != 0) begin
         for (int i = 0; i < 6; i++) begin
            check_eq("ign_busy", busy, 0);
            check_eq("ign_valid", card_valid, 0);
            @(posedge clock); #1;
         end
         check_outputs("ign");
         return;
      end
      check_eq("busy_start", busy, 1);
      rej = 0;
      s = m_lfsr;
      if (load != 0) begin
         exp_rank = (rank >= 1 && rank <= 13) ? rank : 10;
      end else begin
         while (!(s[3:0] >= 4'd1 && s[3:0] <= 4'd13)) begin
            s = lfsr_step(s);
            rej++;
         end
         exp_rank = int'(s[3:0]);
      end
      v = card_val(exp_rank);
      m_total[tgt] += v;
      if (v == 11 && m_soft[tgt] < 3) m_soft[tgt]++;
      down = 0;
      while (m_total[tgt] > 21 && m_soft[tgt] > 0) begin
         m_total[tgt] -= 10;
         m_soft[tgt]--;
         down++;
      end
      m_val = v;
      m_tgt = tgt;
      m_bust[0] = (m_total[0] > 21) ? 1 : 0;
      m_bust[1] = (m_total[1] > 21) ? 1 : 0;
      m_disp = (m_bust[0] != 0 || m_bust[1] != 0) ? 2 : tgt;
      lat = 1;
      seen = 1'b0;
      while (!seen && lat < 80) begin
         @(posedge clock); #1;
         lat++;
         if (card_valid) seen = 1'b1;
      end
      check_eq("valid_seen", seen, 1);
      check_eq("latency", lat, 4 + rej + down);
      check_outputs("deal");
      check_eq("value_range", (card_value >= 5'd2 && card_value <= 5'd11) ? 1 : 0, 1);
      check_eq("busy_done", busy, 1);
      @(posedge clock); #1;
      check_eq("valid_pulse", card_valid, 0);
      check_eq("busy_idle", busy, 0);
      last_lat = lat;
   endtask

   initial begin
      model_clear();
      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_valid", card_valid, 0);
      check_outputs("rst");
      resetn = 1'b1;
      @(posedge clock); #1;

      // Simple hand: 5 + 9
      deal(0, 1, 5);
      check_eq("lat_min", last_lat, 4);
      deal(0, 1, 9);
      check_eq("p14_total", player_total, 14);
      check_eq("p14_value", card_value, 9);
      check_eq("p14_disp", disp_sel, 0);

      // Soft 20 plus an ace downgrades once to 21
      do_new_hand();
      deal(0, 1, 1);
      deal(0, 1, 9);
      check_eq("soft20", player_total, 20);
      deal(0, 1, 1);
      check_eq("p21_total", player_total, 21);
      check_eq("p21_lat", last_lat, 5);
      check_eq("p21_bust", player_bust, 0);

      // Multiple aces, then a hard card that busts the player
      do_new_hand();
      deal(0, 1, 1);
      deal(0, 1, 1);
      check_eq("aa12", player_total, 12);
      deal(0, 1, 1);
      deal(0, 1, 9);
      deal(0, 1, 10);
      check_eq("pbust_flag", player_bust, 1);
      check_eq("pbust_disp", disp_sel, 2);

      // Dealer bust; further dealer requests ignored, player still dealt
      do_new_hand();
      deal(1, 1, 13);
      deal(1, 1, 12);
      deal(1, 1, 2);
      check_eq("d22_total", dealer_total, 22);
      check_eq("d22_bust", dealer_bust, 1);
      check_eq("d22_disp", disp_sel, 2);
      deal(1, 1, 5);
      deal(0, 1, 3);
      check_eq("disp_held", disp_sel, 2);

      // Out-of-range forced ranks count as 10
      do_new_hand();
      deal(0, 1, 0);
      deal(0, 1, 15);
      check_eq("forced20", player_total, 20);

      // Abort a dealer deal in ADD with new_hand
      do_new_hand();
      deal_req = 1'b1; deal_target = 1'b1; card_load = 1'b1; card_rank = 4'd5;
      @(posedge clock); #1;
      deal_req = 1'b0; card_load = 1'b0;
      @(posedge clock); #1;
      new_hand = 1'b1;
      @(posedge clock); #1;
      new_hand = 1'b0;
      model_clear();
      m_val = 5;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_ptot", player_total, 0);
      check_eq("abort_dtot", dealer_total, 0);
      check_eq("abort_disp", disp_sel, 0);
      for (int i = 0; i < 6; i++) begin
         check_eq("abort_valid", card_valid, 0);
         @(posedge clock); #1;
      end

      // new_hand and deal_req together: request dropped
      new_hand = 1'b1; deal_req = 1'b1; deal_target = 1'b0; card_load = 1'b1; card_rank = 4'd7;
      @(posedge clock); #1;
      new_hand = 1'b0; deal_req = 1'b0; card_load = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check_eq("drop_busy", busy, 0);
         check_eq("drop_valid", card_valid, 0);
         @(posedge clock); #1;
      end
      check_outputs("drop");

      // Randomized LFSR deals
      do_new_hand();
      for (int n = 0; n < 200; n++) begin
         if (m_bust[0] != 0 || m_bust[1] != 0 || $urandom_range(0, 3) == 0) do_new_hand();
         repeat ($urandom_range(0, 3)) begin
            @(posedge clock); #1;
         end
         deal($urandom_range(0, 1), 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
